cpu_pc_ctrl: RTL and testbench

Program-counter sequencer for the one-cycle CPU. Holds the PC and base-address register and owns a hardware call/return stack. Each enabled cycle it selects the next fetch address from the decoded flow-control op: sequential, absolute jump, base-relative jump, CALL, RET or HALT. Sits between instruction decode and program memory address input; replaces ad-hoc next-address muxing in the core.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/cpu_pc_ctrl_if.sv | 25 ++
 rtl/cpu_call_stack.sv | 53 +++++
 rtl/cpu_pc_ctrl.sv | 98 +++++++++
 tb/tb_cpu_pc_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the PC sequencer: flow-control opcodes and sequencer states.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_NEXT    = 3'b000,
    OP_JMP_ABS = 3'b001,
    OP_JMP_REL = 3'b010,
    OP_CALL    = 3'b011,
    OP_RET     = 3'b100,
    OP_HALT    = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b10
  } state_e;

endpackage

// File: rtl/cpu_pc_ctrl_if.sv
// Decode-to-sequencer bus: flow-control request in, fetch address and status out.
interface cpu_pc_ctrl_if #(parameter int WIDTH = 8);
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic             base_ld;
  logic [WIDTH-1:0] base_data;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] lr_top;
  logic             stack_empty;
  logic             stack_full;
  logic             halted;
  logic             fault;

  modport master (
    output en, op, target, base_ld, base_data, resume,
    input  pc, lr_top, stack_empty, stack_full, halted, fault
  );

  modport slave (
    input  en, op, target, base_ld, base_data, resume,
    output pc, lr_top, stack_empty, stack_full, halted, fault
  );
endinterface

// File: rtl/cpu_call_stack.sv
// Hardware return-address LIFO. With CPU_PC_CTRL_STACK_WRAP_EN defined the buffer is
// circular and a push when full overwrites the oldest entry.
module cpu_call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign top_ptr = wr_ptr - 1'b1;
  assign top     = empty ? '0 : mem[top_ptr];
  assign pop_ok  = pop && !empty;
`ifdef CPU_PC_CTRL_STACK_WRAP_EN
  // When full, wr_ptr already points at the oldest entry, so a push recycles it.
  assign push_ok = push;
`else
  assign push_ok = push && !full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop_ok) begin
      wr_ptr <= wr_ptr - 1'b1;
      count  <= count - 1'b1;
    end
  end
endmodule

// File: rtl/cpu_pc_ctrl.sv
// Program-counter sequencer: PC, base register, RUN/HALTED/FAULT FSM and call stack.
// Optional CPU_PC_CTRL_STACK_WRAP_EN makes call-stack overflow wrap instead of fault.
module cpu_pc_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_pc_ctrl_if.slave bus
);
`ifdef CPU_PC_CTRL_STACK_WRAP_EN
  localparam bit STACK_WRAP = 1'b1;
`else
  localparam bit STACK_WRAP = 1'b0;
`endif

  state_e           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt, pc_plus1, base;
  logic [WIDTH-1:0] lr_top;
  logic             push, pop, stk_empty, stk_full;

  assign pc_plus1 = pc + 1'b1;

  cpu_call_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (lr_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc    <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // Loaded after the mux reads it, so a same-cycle JMP_REL sees the old base.
      if (bus.base_ld && state != ST_FAULT) base <= bus.base_data;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.en) begin
          case (bus.op)
            OP_JMP_ABS: pc_nxt = bus.target;
            OP_JMP_REL: pc_nxt = base + bus.target;
            OP_CALL: begin
              if (stk_full && !STACK_WRAP) begin
                state_nxt = ST_FAULT;
              end else begin
                push   = 1'b1;
                pc_nxt = bus.target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state_nxt = ST_FAULT;
              end else begin
                pop    = 1'b1;
                pc_nxt = lr_top;
              end
            end
            OP_HALT: state_nxt = ST_HALTED;
            default: pc_nxt = pc_plus1;
          endcase
        end
      end
      ST_HALTED: begin
        if (bus.en && bus.resume) begin
          pc_nxt    = pc_plus1;
          state_nxt = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc          = pc;
  assign bus.lr_top      = lr_top;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_full  = stk_full;
  assign bus.halted      = (state == ST_HALTED);
  assign bus.fault       = (state == ST_FAULT);
endmodule

// File: tb/tb_cpu_pc_ctrl.sv
// Directed and randomized bench for cpu_pc_ctrl against a queue-based reference model.
module tb_cpu_pc_ctrl;
  localparam int W = 8;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cpu_pc_ctrl_if #(.WIDTH(W)) bus ();

  cpu_pc_ctrl #(.WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [W-1:0] m_pc, m_base;
  logic [W-1:0] m_stk [$];
  bit           m_halted, m_fault;

  function automatic void model_reset();
    m_pc = '0; m_base = '0; m_halted = 0; m_fault = 0;
    m_stk.delete();
  endfunction

  function automatic void model_step(bit en, logic [2:0] op, logic [W-1:0] tgt,
                                     bit bld, logic [W-1:0] bdata, bit res);
    if (m_fault) return;
    if (m_halted) begin
      if (en && res) begin m_pc = m_pc + 1'b1; m_halted = 0; end
    end else if (en) begin
      case (op)
        3'd1: m_pc = tgt;
        3'd2: m_pc = m_base + tgt;
        3'd3: begin
          if (m_stk.size() == D) begin
`ifdef CPU_PC_CTRL_STACK_WRAP_EN
            void'(m_stk.pop_front());
            m_stk.push_back(m_pc + 1'b1);
            m_pc = tgt;
`else
            m_fault = 1;
`endif
          end else begin
            m_stk.push_back(m_pc + 1'b1);
            m_pc = tgt;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) m_fault = 1;
          else m_pc = m_stk.pop_back();
        end
        3'd5: m_halted = 1;
        default: m_pc = m_pc + 1'b1;
      endcase
    end
    if (bld) m_base = bdata;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".pc"},     32'(bus.pc),          32'(m_pc));
    chk({tag, ".lr_top"}, 32'(bus.lr_top),      32'(m_stk.size() == 0 ? '0 : m_stk[$]));
    chk({tag, ".empty"},  32'(bus.stack_empty), 32'(m_stk.size() == 0));
    chk({tag, ".full"},   32'(bus.stack_full),  32'(m_stk.size() == D));
    chk({tag, ".halted"}, 32'(bus.halted),      32'(m_halted));
    chk({tag, ".fault"},  32'(bus.fault),       32'(m_fault));
  endtask

  // Called at a negedge: drive, take one rising edge, compare at the next negedge.
  task automatic step(string tag, bit en, logic [2:0] op, logic [W-1:0] tgt,
                      bit bld = 0, logic [W-1:0] bdata = '0, bit res = 0);
    bus.en = en; bus.op = op; bus.target = tgt;
    bus.base_ld = bld; bus.base_data = bdata; bus.resume = res;
    @(posedge clk);
    model_step(en, op, tgt, bld, bdata, res);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_all("reset");
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    bus.en = 0; bus.op = '0; bus.target = '0;
    bus.base_ld = 0; bus.base_data = '0; bus.resume = 0;
    model_reset();
    do_reset();

    // 1: sequential fetch
    for (int i = 0; i < 3; i++) step("next", 1, 3'd0, '0);
    chk("tp1.pc", 32'(bus.pc), 32'h3);

    // 2: base load concurrent with relative jump, then wrap of base+offset
    step("rel0", 1, 3'd2, 8'h05, 1, 8'h40);
    chk("tp2.old_base", 32'(bus.pc), 32'h05);
    step("rel1", 1, 3'd2, 8'hC5);
    chk("tp2.wrap", 32'(bus.pc), 32'h05);
    step("stall", 0, 3'd1, 8'hEE, 1, 8'h00);

    // 3: nested call/return
    step("abs", 1, 3'd1, 8'h10);
    step("call0", 1, 3'd3, 8'h80);
    chk("tp3.lr0", 32'(bus.lr_top), 32'h11);
    step("call1", 1, 3'd3, 8'h90);
    chk("tp3.lr1", 32'(bus.lr_top), 32'h81);
    step("ret0", 1, 3'd4, '0);
    chk("tp3.ret0", 32'(bus.pc), 32'h81);
    step("ret1", 1, 3'd4, '0);
    chk("tp3.ret1", 32'(bus.pc), 32'h11);
    chk("tp3.empty", 32'(bus.stack_empty), 32'h1);

    // Return address wraps from all-ones
    step("abs_ff", 1, 3'd1, 8'hFF);
    step("call_ff", 1, 3'd3, 8'h30);
    chk("wrap.lr", 32'(bus.lr_top), 32'h00);
    step("ret_ff", 1, 3'd4, '0);

    // 4: five calls into a four-deep stack
    do_reset();
    for (int i = 0; i < 5; i++) step("call5", 1, 3'd3, 8'(8'h20 * (i + 1)));
`ifdef CPU_PC_CTRL_STACK_WRAP_EN
    chk("tp4.nofault", 32'(bus.fault), 32'h0);
    for (int i = 0; i < 4; i++) step("ret4", 1, 3'd4, '0);
    chk("tp4.lastret", 32'(bus.pc), 32'h21);
`else
    chk("tp4.fault", 32'(bus.fault), 32'h1);
    chk("tp4.pc", 32'(bus.pc), 32'h80);
    step("ign0", 1, 3'd1, 8'h55, 1, 8'h77);
    step("ign1", 1, 3'd4, '0);
    step("ign2", 1, 3'd2, 8'h01);
`endif

    // 5: underflow then asynchronous reset mid-cycle
    do_reset();
    step("abs5", 1, 3'd1, 8'h44);
    step("uflow", 1, 3'd4, '0);
    chk("tp5.fault", 32'(bus.fault), 32'h1);
    chk("tp5.pc", 32'(bus.pc), 32'h44);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("tp5.async_pc", 32'(bus.pc), 32'h0);
    chk("tp5.async_fault", 32'(bus.fault), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all("post_async");

    // 6: halt, ignored ops, resume gating
    step("abs6", 1, 3'd1, 8'h20);
    step("halt", 1, 3'd5, '0);
    chk("tp6.halted", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 5; i++) step("hold", 1, 3'd1, 8'h99);
    chk("tp6.hold", 32'(bus.pc), 32'h20);
    step("res_en0", 0, 3'd0, '0, 0, '0, 1);
    chk("tp6.res_en0", 32'(bus.halted), 32'h1);
    step("res_en1", 1, 3'd0, '0, 0, '0, 1);
    chk("tp6.resume_pc", 32'(bus.pc), 32'h21);
    chk("tp6.resume_run", 32'(bus.halted), 32'h0);

    // Randomized mix against the model
    for (int i = 0; i < 800; i++) begin
      if (m_fault || $urandom_range(0, 80) == 0) do_reset();
      step("rnd", $urandom_range(0, 5) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
           $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
